// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: bundles the execute-side request/response signals and the
// port-B RAM signals of the load/store unit.
//   master : view taken by lsu_mem_port (accepts requests, drives the RAM port,
//            returns load data, store completion and faults)
//   slave  : view taken by the execute stage plus RAM model
// Signals:
//   req_*          request from execute (valid/ready handshake)
//   mem_op/addr/din  registered RAM command, mem_dout/mem_bvalid RAM read return,
//   mem_notready   RAM stall
//   ld_*, st_done, fault, fault_code  completion and error reporting
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic [1:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_bvalid;
    logic        mem_notready;

    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        st_done;
    logic        fault;
    logic [1:0]  fault_code;

    modport master (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_dout, mem_bvalid, mem_notready,
        output req_ready,
        output mem_op, mem_addr, mem_din,
        output ld_valid, ld_data, ld_rd, st_done, fault, fault_code
    );

    modport slave (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        output mem_dout, mem_bvalid, mem_notready,
        input  req_ready,
        input  mem_op, mem_addr, mem_din,
        input  ld_valid, ld_data, ld_rd, st_done, fault, fault_code
    );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator for the data port (port B) of the
// single-cycle word RAM. Turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into
// word-granular RAM operations; sub-word stores use read-modify-write.
// Ports:
//   clk     clock
//   reset   synchronous, active-high
//   io_bus  lsu_mem_port_if.master: request handshake, RAM command/return,
//           load result, store completion and fault reporting
module lsu_mem_port #(
    parameter logic [1:0]  MEM_DISABLE    = 2'b00,
    parameter logic [1:0]  MEM_READ_SEXT  = 2'b01,
    parameter logic [1:0]  MEM_READ_ZEXT  = 2'b10,
    parameter logic [1:0]  MEM_WRITE      = 2'b11,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset,
    lsu_mem_port_if.master io_bus
);
    localparam int unsigned     CntW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] FaultMisaligned = 2'b01;
    localparam logic [1:0] FaultIllegal    = 2'b10;
    localparam logic [1:0] FaultTimeout    = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StWrite} state_e;

    state_e          r_state;
    logic [1:0]      r_mem_op;
    logic [31:0]     r_mem_addr;
    logic [31:0]     r_mem_din;
    logic [31:0]     r_ld_data;
    logic [4:0]      r_ld_rd;
    logic [1:0]      r_fault_code;
    logic            r_ld_valid;
    logic            r_st_done;
    logic            r_fault;
    logic [CntW-1:0] r_cnt;
    // Latched request fields
    logic            r_store;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;
    logic [15:0]     r_wdata;
    logic [4:0]      r_rd;

    logic            w_ready;
    logic            w_accept;
    logic            w_legal;
    logic            w_misaligned;
    logic            w_word_store;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_ld_result;
    logic [31:0]     w_merged;

    assign w_ready  = (r_state == StIdle) && !io_bus.mem_notready;
    assign w_accept = io_bus.req_valid && w_ready;

    always_comb begin
        w_legal = 1'b0;
        case (io_bus.req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !io_bus.req_store;
            default:                w_legal = 1'b0;
        endcase
    end

    assign w_misaligned = ((io_bus.req_funct3[1:0] == 2'b01) && io_bus.req_addr[0]) ||
                          ((io_bus.req_funct3[1:0] == 2'b10) && (io_bus.req_addr[1:0] != 2'b00));
    assign w_word_store = io_bus.req_store && (io_bus.req_funct3 == 3'b010);

    // Lane extraction and extension of the returned RAM word
    always_comb begin
        w_byte = io_bus.mem_dout[7:0];
        unique case (r_lane)
            2'd0: w_byte = io_bus.mem_dout[7:0];
            2'd1: w_byte = io_bus.mem_dout[15:8];
            2'd2: w_byte = io_bus.mem_dout[23:16];
            2'd3: w_byte = io_bus.mem_dout[31:24];
        endcase
        w_half = r_lane[1] ? io_bus.mem_dout[31:16] : io_bus.mem_dout[15:0];
        case (r_funct3)
            3'b000:  w_ld_result = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_result = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_result = {24'h0, w_byte};
            3'b101:  w_ld_result = {16'h0, w_half};
            default: w_ld_result = io_bus.mem_dout;
        endcase
    end

    // Read-modify-write merge: new byte/half replaces its lane, others kept
    always_comb begin
        w_merged = io_bus.mem_dout;
        if (r_funct3[1:0] == 2'b00) begin
            unique case (r_lane)
                2'd0: w_merged[7:0]   = r_wdata[7:0];
                2'd1: w_merged[15:8]  = r_wdata[7:0];
                2'd2: w_merged[23:16] = r_wdata[7:0];
                2'd3: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_wdata;
        end else begin
            w_merged[15:0] = r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_mem_op     <= MEM_DISABLE;
            r_mem_addr   <= 32'h0;
            r_mem_din    <= 32'h0;
            r_ld_data    <= 32'h0;
            r_ld_rd      <= 5'h0;
            r_fault_code <= 2'b00;
            r_ld_valid   <= 1'b0;
            r_st_done    <= 1'b0;
            r_fault      <= 1'b0;
            r_cnt        <= '0;
            r_store      <= 1'b0;
            r_funct3     <= 3'b000;
            r_lane       <= 2'b00;
            r_wdata      <= 16'h0;
            r_rd         <= 5'h0;
        end else begin
            r_ld_valid <= 1'b0;
            r_st_done  <= 1'b0;
            r_fault    <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            r_fault      <= 1'b1;
                            r_fault_code <= FaultIllegal;
                        end else if (w_misaligned) begin
                            r_fault      <= 1'b1;
                            r_fault_code <= FaultMisaligned;
                        end else begin
                            r_store    <= io_bus.req_store;
                            r_funct3   <= io_bus.req_funct3;
                            r_lane     <= io_bus.req_addr[1:0];
                            r_wdata    <= io_bus.req_wdata[15:0];
                            r_rd       <= io_bus.req_rd;
                            r_mem_addr <= {io_bus.req_addr[31:2], 2'b00};
                            if (w_word_store) begin
                                r_mem_op  <= MEM_WRITE;
                                r_mem_din <= io_bus.req_wdata;
                            end else if (io_bus.req_store || io_bus.req_funct3[2]) begin
                                // Sub-word stores read unextended for the merge
                                r_mem_op <= MEM_READ_ZEXT;
                            end else begin
                                r_mem_op <= MEM_READ_SEXT;
                            end
                            r_state <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    r_mem_op <= MEM_DISABLE;
                    r_cnt    <= '0;
                    if (r_store && (r_funct3[1:0] == 2'b10)) begin
                        r_st_done <= 1'b1;
                        r_state   <= StIdle;
                    end else begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (io_bus.mem_bvalid) begin
                        if (!r_store) begin
                            r_ld_data  <= w_ld_result;
                            r_ld_rd    <= r_rd;
                            r_ld_valid <= 1'b1;
                            r_state    <= StIdle;
                        end else begin
                            r_mem_din <= w_merged;
                            r_mem_op  <= MEM_WRITE;
                            r_state   <= StWrite;
                        end
                    end else if (r_cnt == CntLast) begin
                        r_fault      <= 1'b1;
                        r_fault_code <= FaultTimeout;
                        r_state      <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWrite: begin
                    r_mem_op  <= MEM_DISABLE;
                    r_st_done <= 1'b1;
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Reset forces the RAM op idle in the same cycle so an RMW cut short by
    // reset never reaches the RAM as a write.
    assign io_bus.mem_op     = reset ? MEM_DISABLE : r_mem_op;
    assign io_bus.req_ready  = w_ready;
    assign io_bus.mem_addr   = r_mem_addr;
    assign io_bus.mem_din    = r_mem_din;
    assign io_bus.ld_valid   = r_ld_valid;
    assign io_bus.ld_data    = r_ld_data;
    assign io_bus.ld_rd      = r_ld_rd;
    assign io_bus.st_done    = r_st_done;
    assign io_bus.fault      = r_fault;
    assign io_bus.fault_code = r_fault_code;
endmodule
